fib_seq_checker: RTL and testbench

Receive-side checker for the Fibonacci byte stream produced by the project's sequence generator. Reassembles byte-serial terms, compares each against the expected recurrence, and reports per-term pass/fail pulses plus term and error counters. Sits on the consuming end of the generator's output bus, in the cocotb harness and on-chip as a loopback self-test.

---
 rtl/fib_seq_pkg.sv | 21 ++
 rtl/fib_term_assembler.sv | 47 ++++
 rtl/fib_seq_checker.sv | 125 ++++++++++++
 tb/tb_fib_seq_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci stream checker.
// Optional build macro: FIB_CHECK_RESYNC_EN (see fib_seq_checker).
package fib_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    COLLECT = 2'd2
  } state_t;

  localparam int FIB_SEED0    = 0;
  localparam int FIB_SEED1    = 1;
  localparam int TERM_COUNT_W = 16;
  localparam int ERR_COUNT_W  = 8;

  // Error counter increments but sticks at all-ones.
  function automatic logic [ERR_COUNT_W-1:0] err_inc(input logic [ERR_COUNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/fib_term_assembler.sv
// Byte-serial, LSB-first term capture. The completed term is presented
// combinationally on the cycle its final byte arrives.
module fib_term_assembler #(
  parameter int WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic                             push_i,
  input  logic                             drop_i,
  input  logic [7:0]                       byte_i,
  output logic [$clog2(WIDTH/8)-1:0]       idx_o,
  output logic                             last_o,
  output logic [WIDTH-1:0]                 term_o
);

  localparam int BYTES = WIDTH / 8;
  localparam int IDX_W = $clog2(BYTES);

  logic [IDX_W-1:0]   idx_q;
  // The top byte is never stored: it is taken straight from the bus.
  logic [WIDTH-9:0]   data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      data_q <= '0;
    end else if (drop_i) begin
      idx_q <= '0;
    end else if (start_i) begin
      data_q[7:0] <= byte_i;
      idx_q       <= IDX_W'(1);
    end else if (push_i) begin
      if (last_o) begin
        idx_q <= '0;
      end else begin
        data_q[idx_q*8 +: 8] <= byte_i;
        idx_q                <= idx_q + IDX_W'(1);
      end
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == IDX_W'(BYTES - 1));
  assign term_o = {byte_i, data_q};

endmodule

// File: rtl/fib_seq_checker.sv
// Receive-side Fibonacci stream checker: compare, recurrence, pulses, counters.
// Build macro FIB_CHECK_RESYNC_EN: expected term tracks the received stream.
module fib_seq_checker
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [7:0]              data_in,
  input  logic                    data_valid,
  input  logic                    data_first,
  output logic                    term_ok,
  output logic                    term_bad,
  output logic                    err_sticky,
  output logic [TERM_COUNT_W-1:0] term_count,
  output logic [ERR_COUNT_W-1:0]  err_count,
  output logic                    locked
);

  localparam int BYTES = WIDTH / 8;
  localparam int IDX_W = $clog2(BYTES);

  state_t                  state_q;
  logic [WIDTH-1:0]        a_q, b_q;
  logic                    ok_q, bad_q, sticky_q, locked_q;
  logic [TERM_COUNT_W-1:0] tcnt_q;
  logic [ERR_COUNT_W-1:0]  ecnt_q;

  logic [IDX_W-1:0]        asm_idx;
  logic                    asm_last;
  logic [WIDTH-1:0]        asm_term;
  logic                    sync_hit, frame_err, asm_start, asm_push, complete, match;

  assign sync_hit  = en && data_valid && data_first && (state_q == SYNC);
  assign frame_err = en && data_valid && data_first && (state_q == COLLECT) && (asm_idx != '0);
  assign asm_start = sync_hit || frame_err;
  assign asm_push  = en && data_valid && !data_first && (state_q == COLLECT);
  assign complete  = asm_push && asm_last;
  assign match     = (asm_term == a_q);

  fib_term_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk     (clk),
    .rst     (rst),
    .start_i (asm_start),
    .push_i  (asm_push),
    .drop_i  (!en),
    .byte_i  (data_in),
    .idx_o   (asm_idx),
    .last_o  (asm_last),
    .term_o  (asm_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= WIDTH'(FIB_SEED0);
      b_q      <= WIDTH'(FIB_SEED1);
      ok_q     <= 1'b0;
      bad_q    <= 1'b0;
      sticky_q <= 1'b0;
      locked_q <= 1'b0;
      tcnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      ok_q  <= 1'b0;
      bad_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            state_q  <= SYNC;
            tcnt_q   <= '0;
            ecnt_q   <= '0;
            sticky_q <= 1'b0;
            locked_q <= 1'b0;
            a_q      <= WIDTH'(FIB_SEED0);
            b_q      <= WIDTH'(FIB_SEED1);
          end
          SYNC: begin
            if (sync_hit) begin
              state_q  <= COLLECT;
              locked_q <= 1'b1;
            end
          end
          COLLECT: begin
            if (frame_err) begin
              bad_q    <= 1'b1;
              sticky_q <= 1'b1;
              ecnt_q   <= err_inc(ecnt_q);
            end else if (complete) begin
              ok_q    <= match;
              bad_q   <= !match;
              tcnt_q  <= tcnt_q + 1'b1;
              state_q <= SYNC;
              if (!match) begin
                sticky_q <= 1'b1;
                ecnt_q   <= err_inc(ecnt_q);
              end
`ifdef FIB_CHECK_RESYNC_EN
              // b_q holds the previous received term; next expected is the sum of the last two.
              a_q <= asm_term + b_q;
              b_q <= asm_term;
`else
              a_q <= b_q;
              b_q <= a_q + b_q;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign term_ok    = ok_q;
  assign term_bad   = bad_q;
  assign err_sticky = sticky_q;
  assign term_count = tcnt_q;
  assign err_count  = ecnt_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_fib_seq_checker.sv
// Self-checking bench for fib_seq_checker against a term-level reference model.
module tb_fib_seq_checker;

  localparam int WIDTH = 32;
  localparam int BYTES = WIDTH / 8;

  logic        clk = 1'b0;
  logic        rst, en, data_valid, data_first;
  logic [7:0]  data_in;
  logic        term_ok, term_bad, err_sticky, locked;
  logic [15:0] term_count;
  logic [7:0]  err_count;

  fib_seq_checker #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_first (data_first),
    .term_ok    (term_ok),
    .term_bad   (term_bad),
    .err_sticky (err_sticky),
    .term_count (term_count),
    .err_count  (err_count),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: ideal Fibonacci table plus per-run bookkeeping.
  logic [31:0] fib [0:399];
  logic [31:0] rx_q [$];
  int          k;
  logic [15:0] m_tcnt;
  int          m_ecnt;
  bit          m_sticky;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expected_term();
`ifdef FIB_CHECK_RESYNC_EN
    if (k == 0) return 32'd0;
    if (k == 1) return rx_q[0] + 32'd1;
    return rx_q[k-1] + rx_q[k-2];
`else
    return fib[k];
`endif
  endfunction

  task automatic model_bad();
    if (m_ecnt < 255) m_ecnt++;
    m_sticky = 1'b1;
  endtask

  // One clock of stimulus, then check the pulses that this byte produced.
  task automatic step(input logic [7:0] b, input bit v, input bit f, input bit eok, input bit ebad);
    @(negedge clk);
    data_in    = b;
    data_valid = v;
    data_first = f;
    @(posedge clk);
    #1;
    chk("pulse", {term_ok, term_bad}, {eok, ebad});
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, ".tcnt"}, term_count, m_tcnt);
    chk({tag, ".ecnt"}, err_count, 64'(m_ecnt));
    chk({tag, ".sticky"}, err_sticky, m_sticky);
  endtask

  task automatic start_run();
    @(negedge clk);
    en = 1'b0;
    data_valid = 1'b0;
    data_first = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    k = 0; m_tcnt = 0; m_ecnt = 0; m_sticky = 0;
    rx_q.delete();
    chk_counts("run_start");
  endtask

  // Send one term; abort_at>0 first sends that many junk bytes of an aborted term.
  task automatic send_term(input logic [31:0] value, input int abort_at, input bit gaps);
    bit          pend, ok;
    logic [31:0] expv;
    for (int i = 0; i < abort_at; i++) step(8'($urandom), 1'b1, i == 0, 1'b0, 1'b0);
    pend = (abort_at > 0);
    for (int i = 0; i < BYTES; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        if (pend) model_bad();
        step(value[7:0], 1'b1, 1'b1, 1'b0, pend);
        chk("locked", locked, 1);
        if (pend) chk_counts("frame");
      end else if (i == BYTES - 1) begin
        expv = expected_term();
        ok   = (value == expv);
        rx_q.push_back(value);
        k++;
        m_tcnt++;
        if (!ok) model_bad();
        step(value[i*8 +: 8], 1'b1, 1'b0, ok, !ok);
        chk_counts("term");
      end else begin
        step(value[i*8 +: 8], 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    fib[0] = 32'd0;
    fib[1] = 32'd1;
    for (int i = 2; i < 400; i++) fib[i] = fib[i-1] + fib[i-2];

    rst = 1'b1; en = 1'b0; data_valid = 1'b0; data_first = 1'b0; data_in = 8'h00;
    k = 0; m_tcnt = 0; m_ecnt = 0; m_sticky = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {term_ok, term_bad, err_sticky, locked, term_count, err_count}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ten correct terms back-to-back.
    start_run();
    for (int i = 0; i < 10; i++) send_term(fib[i], 0, 1'b0);
    chk("ten_terms", term_count, 10);

    // Fifth term corrupted (4 instead of 3).
    start_run();
    for (int i = 0; i < 10; i++) send_term((i == 4) ? 32'd4 : fib[i], 0, 1'b0);

    // Framing error on byte 2 of the third term, restarted term must pass.
    start_run();
    send_term(fib[0], 0, 1'b0);
    send_term(fib[1], 0, 1'b0);
    send_term(fib[2], 2, 1'b0);

    // 49 ideal terms crossing the 2^32 wrap at F48.
    start_run();
    for (int i = 0; i <= 48; i++) send_term(fib[i], 0, 1'b0);

    // Drop en mid-term: counters hold.
    start_run();
    send_term(fib[0], 0, 1'b0);
    step(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b0; data_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("en_drop_pulse", {term_ok, term_bad}, 0);
    chk_counts("en_drop");

    // en low on the completing byte: no pulse, no count.
    start_run();
    step(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < BYTES - 1; i++) step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b0; data_in = 8'h00; data_valid = 1'b1; data_first = 1'b0;
    @(posedge clk);
    #1;
    chk("en_wins_pulse", {term_ok, term_bad}, 0);
    chk_counts("en_wins");

    // Re-enable: counters cleared, 0 and 1 pass.
    start_run();
    send_term(fib[0], 0, 1'b0);
    send_term(fib[1], 0, 1'b0);

    // Asynchronous reset mid-term after an error.
    send_term(fib[2], 1, 1'b0);
    step(8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {term_ok, term_bad, err_sticky, locked, term_count, err_count}, 0);
    @(posedge clk);
    #1;
    chk("rst_next", {term_ok, term_bad, err_sticky, locked, term_count, err_count}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Stream offset from the ideal sequence: error counter saturates.
    start_run();
    for (int i = 0; i < 300; i++) send_term(fib[i+2], 0, 1'b0);
    chk("sat_ecnt", err_count, 255);
    chk("sat_tcnt", term_count, 300);

    // Randomized: gaps, stray bytes, corrupted terms, framing aborts.
    start_run();
    for (int n = 0; n < 150; n++) begin
      logic [31:0] v;
      int          ab;
      if ($urandom_range(0, 7) == 0) step(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      v = fib[k];
      if ($urandom_range(0, 7) == 0) v = v ^ (32'd1 << $urandom_range(0, 31));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, BYTES - 1)) : 0;
      send_term(v, ab, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
